// File: rtl/add20_arbiter.sv
// ============================================================================
// Module   : add20_arbiter
// Purpose  : Round-robin sharing of one 20-bit adder among NREQ requesters,
//            with operand capture, one execute cycle and a held response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add20 (
    input  logic [19:0] a,
    input  logic [19:0] b,
    output logic [19:0] out,
    output logic        cout
);
    assign {cout, out} = {1'b0, a} + {1'b0, b};
endmodule

module add20_arbiter #(
    parameter int WIDTH = 20,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   scan_idx;
    logic [WIDTH-1:0] add_out;
    logic             add_cout;

    add20 u_add20 (
        .a    (op_a_q),
        .b    (op_b_q),
        .out  (add_out),
        .cout (add_cout)
    );

    // Scan starts at the pointer; IDW-bit addition wraps modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + k[IDW-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = '0;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d[win_id] = 1'b1;
                    op_a_d        = a_in[win_id*WIDTH +: WIDTH];
                    op_b_d        = b_in[win_id*WIDTH +: WIDTH];
                    id_d          = win_id;
                    ptr_d         = win_id + 1'b1;
                end
            end
            S_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_sum_d   = add_out;
                rsp_cout_d  = add_cout;
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_add20_arbiter.sv
// ============================================================================
// Module   : tb_add20_arbiter
// Purpose  : Directed self-checking bench for add20_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add20_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [79:0] a_in;
    logic [79:0] b_in;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [19:0] rsp_sum;
    logic        rsp_cout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    add20_arbiter #(.WIDTH(20), .NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [19:0] a, input logic [19:0] b);
        a_in[i*20 +: 20] = a;
        b_in[i*20 +: 20] = b;
    endtask

    // Called at a negedge before the sampling edge; returns at the negedge
    // after the handshake with the FSM back in IDLE.
    task automatic run_op(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                          input logic [19:0] exp_sum, input logic exp_cout);
        tick();
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check_eq({tag, "_busy_exec"}, 32'(busy), 32'd1);
        check_eq({tag, "_valid_exec"}, 32'(rsp_valid), 32'd0);
        tick();
        check_eq({tag, "_gnt_resp"}, 32'(gnt), 32'd0);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check_eq({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check_eq({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        tick();
        check_eq({tag, "_valid_idle"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1111;
        rsp_ready = 1'b1;
        a_in      = {4{20'hABCDE}};
        b_in      = {4{20'h12345}};

        // Reset held with all requests up
        tick();
        tick();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sum", 32'(rsp_sum), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        check_eq("rst_cout", 32'(rsp_cout), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        check_eq("idle_gnt", 32'(gnt), 32'd0);

        // Single op from requester 0
        set_ops(0, 20'h7FFFF, 20'h00001);
        req = 4'b0001;
        run_op("single", 4'b0001, 2'd0, 20'h80000, 1'b0);
        req = 4'b0000;

        // Carry and wrap on requester 2 (pointer now 1)
        set_ops(2, 20'hFFFFF, 20'h00001);
        req = 4'b0100;
        run_op("carry", 4'b0100, 2'd2, 20'h00000, 1'b1);
        set_ops(2, 20'h55555, 20'h55555);
        run_op("alt", 4'b0100, 2'd2, 20'hAAAAA, 1'b0);
        req = 4'b0000;

        // Fairness from a fresh reset
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst2_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        set_ops(0, 20'h00001, 20'h00002);
        set_ops(1, 20'h10000, 20'h20000);
        set_ops(2, 20'hFFFFF, 20'hFFFFF);
        set_ops(3, 20'h12345, 20'h54321);
        req = 4'b1111;
        run_op("rr0", 4'b0001, 2'd0, 20'h00003, 1'b0);
        run_op("rr1", 4'b0010, 2'd1, 20'h30000, 1'b0);
        run_op("rr2", 4'b0100, 2'd2, 20'hFFFFE, 1'b1);
        run_op("rr3", 4'b1000, 2'd3, 20'h66666, 1'b0);
        run_op("rr4", 4'b0001, 2'd0, 20'h00003, 1'b0);
        req = 4'b1001;
        run_op("rr5", 4'b1000, 2'd3, 20'h66666, 1'b0);
        run_op("rr6", 4'b0001, 2'd0, 20'h00003, 1'b0);

        // Backpressure: requester 0 served (pointer 1), requester 1 waits
        req       = 4'b0001;
        rsp_ready = 1'b0;
        tick();
        check_eq("bp_gnt", 32'(gnt), 32'b0001);
        req = 4'b0010;
        tick();
        check_eq("bp_valid0", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_hold_sum", 32'(rsp_sum), 32'h00003);
            check_eq("bp_hold_id", 32'(rsp_id), 32'd0);
            check_eq("bp_hold_gnt", 32'(gnt), 32'd0);
            check_eq("bp_hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp_release_gnt", 32'(gnt), 32'd0);
        check_eq("bp_release_busy", 32'(busy), 32'd0);
        tick();
        check_eq("bp_next_gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        check_eq("bp_next_id", 32'(rsp_id), 32'd1);
        check_eq("bp_next_sum", 32'(rsp_sum), 32'h30000);
        tick();
        check_eq("bp_next_idle", 32'(busy), 32'd0);

        // Abort: requester 3 granted (pointer 2), reset mid-RESP
        req = 4'b1000;
        tick();
        check_eq("ab_gnt", 32'(gnt), 32'b1000);
        req       = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        check_eq("ab_valid_pre", 32'(rsp_valid), 32'd1);
        check_eq("ab_id_pre", 32'(rsp_id), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ab_valid_async", 32'(rsp_valid), 32'd0);
        check_eq("ab_busy_async", 32'(busy), 32'd0);
        check_eq("ab_sum_async", 32'(rsp_sum), 32'd0);
        check_eq("ab_id_async", 32'(rsp_id), 32'd0);
        tick();
        check_eq("ab_valid_held", 32'(rsp_valid), 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req       = 4'b1010;
        tick();
        check_eq("ab_after_gnt", 32'(gnt), 32'b0010);
        req = 4'b1000;
        tick();
        check_eq("ab_after_id", 32'(rsp_id), 32'd1);
        check_eq("ab_after_sum", 32'(rsp_sum), 32'h30000);
        tick();
        check_eq("ab_after_idle", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("ab_next_gnt", 32'(gnt), 32'b1000);
        req = 4'b0000;
        tick();
        check_eq("ab_next_id", 32'(rsp_id), 32'd3);
        check_eq("ab_next_sum", 32'(rsp_sum), 32'h66666);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
